// File: rtl/router_fsm_np.sv
// Input-side packet-routing FSM for NUM_PORTS output FIFOs with header-latched destination.
// Define ROUTER_FSM_TIMEOUT_EN to build the WAIT_TILL_EMPTY timeout (WTE -> DROP_PACKET).
module router_fsm_np #(
  parameter int unsigned NUM_PORTS    = 3,
  parameter int unsigned ADDR_W       = 2,
  parameter int unsigned WAIT_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 packet_valid,
  input  logic [ADDR_W-1:0]    datain,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_packet_valid,
  output logic [ADDR_W-1:0]    port_sel,
  output logic [3:0]           state_o,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 rst_int_reg,
  output logic                 write_enb_reg,
  output logic                 busy,
  output logic                 drop_state,
  output logic                 timeout_err
);

  localparam int unsigned     NumAddr   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] NumPortsW = (ADDR_W + 1)'(NUM_PORTS);

  if (NUM_PORTS < 2 || NUM_PORTS > NumAddr || WAIT_TIMEOUT < 1) begin : gen_param_check
    $error("router_fsm_np: illegal parameter combination");
  end

  typedef enum logic [3:0] {
    StDa   = 4'd0,
    StWte  = 4'd1,
    StLfd  = 4'd2,
    StLd   = 4'd3,
    StLp   = 4'd4,
    StFfs  = 4'd5,
    StLaf  = 4'd6,
    StCpe  = 4'd7,
    StDrop = 4'd8
  } state_e;

  state_e               state_q, state_d;
  logic [NumAddr-1:0]   empty_ext;
  logic [NumAddr-1:0]   sreset_ext;
  logic                 addr_ok;
  logic                 load_sel;

`ifdef ROUTER_FSM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(WAIT_TIMEOUT + 1);
  logic [CntW-1:0] wait_cnt;
  logic            timeout_hit;
`endif

  // Zero-extend per-port flags so any address value indexes a defined bit.
  always_comb begin
    empty_ext                   = '0;
    empty_ext[NUM_PORTS-1:0]    = fifo_empty;
    sreset_ext                  = '0;
    sreset_ext[NUM_PORTS-1:0]   = soft_reset;
  end

  assign addr_ok  = {1'b0, datain} < NumPortsW;
  assign load_sel = (state_q == StDa) && packet_valid && addr_ok;

  always_comb begin
    state_d = state_q;
`ifdef ROUTER_FSM_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state_q)
      StDa: begin
        if (packet_valid) begin
          if (!addr_ok)               state_d = StDrop;
          else if (empty_ext[datain]) state_d = StLfd;
          else                        state_d = StWte;
        end
      end
      StWte: begin
        if (empty_ext[port_sel]) begin
          state_d = StLfd;
`ifdef ROUTER_FSM_TIMEOUT_EN
        end else if (wait_cnt == CntW'(WAIT_TIMEOUT - 1)) begin
          state_d     = StDrop;
          timeout_hit = 1'b1;
`endif
        end
      end
      StLfd: state_d = StLd;
      StLd: begin
        if (fifo_full)          state_d = StFfs;
        else if (!packet_valid) state_d = StLp;
      end
      StLp:  state_d = StCpe;
      StCpe: state_d = fifo_full ? StFfs : StDa;
      StFfs: begin
        if (!fifo_full) state_d = StLaf;
      end
      StLaf: begin
        if (parity_done)           state_d = StDa;
        else if (low_packet_valid) state_d = StLp;
        else                       state_d = StLd;
      end
      StDrop: begin
        if (!packet_valid) state_d = StDa;
      end
      default: state_d = StDa;
    endcase

    // Read-side abort of the selected port overrides everything but reset.
    if (state_q != StDa && state_q != StDrop && sreset_ext[port_sel]) begin
      state_d = StDa;
`ifdef ROUTER_FSM_TIMEOUT_EN
      timeout_hit = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= StDa;
      port_sel <= '0;
`ifdef ROUTER_FSM_TIMEOUT_EN
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (load_sel) port_sel <= datain;
`ifdef ROUTER_FSM_TIMEOUT_EN
      timeout_err <= timeout_hit;
      // Held at zero outside WTE, so it always starts from zero on entry.
      if (state_q == StWte) wait_cnt <= wait_cnt + CntW'(1);
      else                  wait_cnt <= '0;
`endif
    end
  end

`ifndef ROUTER_FSM_TIMEOUT_EN
  assign timeout_err = 1'b0;
`endif

  assign state_o       = state_q;
  assign detect_add    = (state_q == StDa);
  assign lfd_state     = (state_q == StLfd);
  assign ld_state      = (state_q == StLd);
  assign laf_state     = (state_q == StLaf);
  assign full_state    = (state_q == StFfs);
  assign rst_int_reg   = (state_q == StCpe);
  assign drop_state    = (state_q == StDrop);
  assign write_enb_reg = (state_q == StLd) || (state_q == StLp) || (state_q == StLaf);
  assign busy          = (state_q == StLfd) || (state_q == StLp) || (state_q == StFfs) ||
                         (state_q == StLaf) || (state_q == StWte) || (state_q == StCpe);

endmodule

// File: tb/tb_router_fsm_np.sv
// Directed self-checking bench for router_fsm_np (NUM_PORTS=3, ADDR_W=2, WAIT_TIMEOUT=8).
module tb_router_fsm_np;

  localparam logic [3:0] DA = 4'd0, WTE = 4'd1, LFD = 4'd2, LD = 4'd3, LP = 4'd4;
  localparam logic [3:0] FFS = 4'd5, LAF = 4'd6, CPE = 4'd7, DROP = 4'd8;

  logic       clk = 1'b0;
  logic       resetn;
  logic       packet_valid;
  logic [1:0] datain;
  logic       fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] soft_reset;
  logic       parity_done;
  logic       low_packet_valid;
  logic [1:0] port_sel;
  logic [3:0] state_o;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       rst_int_reg, write_enb_reg, busy, drop_state, timeout_err;
  logic [8:0] dec_obs;

  int checks = 0;
  int errors = 0;

  router_fsm_np #(
    .NUM_PORTS   (3),
    .ADDR_W      (2),
    .WAIT_TIMEOUT(8)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .packet_valid    (packet_valid),
    .datain          (datain),
    .fifo_full       (fifo_full),
    .fifo_empty      (fifo_empty),
    .soft_reset      (soft_reset),
    .parity_done     (parity_done),
    .low_packet_valid(low_packet_valid),
    .port_sel        (port_sel),
    .state_o         (state_o),
    .detect_add      (detect_add),
    .lfd_state       (lfd_state),
    .ld_state        (ld_state),
    .laf_state       (laf_state),
    .full_state      (full_state),
    .rst_int_reg     (rst_int_reg),
    .write_enb_reg   (write_enb_reg),
    .busy            (busy),
    .drop_state      (drop_state),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  assign dec_obs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                    rst_int_reg, write_enb_reg, busy, drop_state};

  // Decode table: {DA, LFD, LD, LAF, FFS, CPE, LD|LP|LAF, busy set, DROP}
  function automatic logic [8:0] dec_exp(input logic [3:0] s);
    logic b;
    b = (s == LFD) || (s == LP) || (s == FFS) || (s == LAF) || (s == WTE) || (s == CPE);
    return {s == DA, s == LFD, s == LD, s == LAF, s == FFS, s == CPE,
            (s == LD) || (s == LP) || (s == LAF), b, s == DROP};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_st(input string tag, input logic [3:0] s);
    check({tag, ".state"}, 32'(state_o), 32'(s));
    check({tag, ".dec"}, 32'(dec_obs), 32'(dec_exp(s)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int bad;
    resetn = 1'b0; packet_valid = 1'b0; datain = 2'd0; fifo_full = 1'b0;
    fifo_empty = 3'b000; soft_reset = 3'b000; parity_done = 1'b0; low_packet_valid = 1'b0;
    tick(); tick();
    expect_st("reset", DA);
    check("reset.port_sel", 32'(port_sel), 32'd0);
    check("reset.timeout_err", 32'(timeout_err), 32'd0);

    // Normal packet to port 1
    resetn = 1'b1; packet_valid = 1'b1; datain = 2'd1; fifo_empty = 3'b111;
    tick(); expect_st("pkt1.lfd", LFD);
    check("pkt1.port_sel", 32'(port_sel), 32'd1);
    tick(); expect_st("pkt1.ld0", LD);
    tick(); expect_st("pkt1.ld1", LD);
    tick(); expect_st("pkt1.ld2", LD);
    packet_valid = 1'b0;
    tick(); expect_st("pkt1.lp", LP);
    tick(); expect_st("pkt1.cpe", CPE);
    tick(); expect_st("pkt1.da", DA);

    // Wait on port 2 while the live address moves to an empty port
    packet_valid = 1'b1; datain = 2'd2; fifo_empty = 3'b011;
    tick(); expect_st("wte.enter", WTE);
    check("wte.port_sel", 32'(port_sel), 32'd2);
    datain = 2'd0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (state_o !== WTE || busy !== 1'b1) bad++;
    end
    check("wte.hold", 32'(bad), 32'd0);
    fifo_empty = 3'b111;
    tick(); expect_st("wte.lfd", LFD);
    tick(); expect_st("wte.ld", LD);

    // Full for three edges, then LAF -> LP via low_packet_valid
    fifo_full = 1'b1;
    tick(); expect_st("ffs.0", FFS);
    tick(); expect_st("ffs.1", FFS);
    tick(); expect_st("ffs.2", FFS);
    fifo_full = 1'b0; low_packet_valid = 1'b1;
    tick(); expect_st("laf.a", LAF);
    tick(); expect_st("laf.a.lp", LP);
    low_packet_valid = 1'b0;
    tick(); expect_st("laf.a.cpe", CPE);
    packet_valid = 1'b0;
    tick(); expect_st("laf.a.da", DA);

    // LAF default -> LD, then LAF with parity_done -> DA
    packet_valid = 1'b1; datain = 2'd0;
    tick(); expect_st("laf.b.lfd", LFD);
    check("laf.b.port_sel", 32'(port_sel), 32'd0);
    tick(); expect_st("laf.b.ld", LD);
    fifo_full = 1'b1;
    tick(); expect_st("laf.b.ffs", FFS);
    fifo_full = 1'b0;
    tick(); expect_st("laf.b.laf", LAF);
    tick(); expect_st("laf.b.ld2", LD);
    fifo_full = 1'b1;
    tick(); expect_st("laf.c.ffs", FFS);
    fifo_full = 1'b0; parity_done = 1'b1;
    tick(); expect_st("laf.c.laf", LAF);
    tick(); expect_st("laf.c.da", DA);
    packet_valid = 1'b0; parity_done = 1'b0;

    // Soft reset: only the selected port aborts
    packet_valid = 1'b1; datain = 2'd2; fifo_empty = 3'b100;
    tick(); expect_st("srst.lfd", LFD);
    tick(); expect_st("srst.ld", LD);
    fifo_full = 1'b1;
    tick(); expect_st("srst.ffs", FFS);
    soft_reset = 3'b001;
    tick(); expect_st("srst.other", FFS);
    soft_reset = 3'b100; packet_valid = 1'b0;
    tick(); expect_st("srst.abort", DA);
    check("srst.port_sel", 32'(port_sel), 32'd2);
    soft_reset = 3'b000; fifo_full = 1'b0;

    // Out-of-range address drops the packet; port_sel untouched
    packet_valid = 1'b1; datain = 2'd3;
    tick(); expect_st("drop.0", DROP);
    check("drop.port_sel", 32'(port_sel), 32'd2);
    tick(); expect_st("drop.1", DROP);
    soft_reset = 3'b100;
    tick(); expect_st("drop.srst", DROP);
    soft_reset = 3'b000; packet_valid = 1'b0;
    tick(); expect_st("drop.da", DA);
    check("drop.port_sel2", 32'(port_sel), 32'd2);

    // Selected FIFO never empties
    packet_valid = 1'b1; datain = 2'd1; fifo_empty = 3'b101;
    tick(); expect_st("to.wte", WTE);
    check("to.port_sel", 32'(port_sel), 32'd1);
`ifdef ROUTER_FSM_TIMEOUT_EN
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (state_o !== WTE || timeout_err !== 1'b0) bad++;
    end
    check("to.wte8", 32'(bad), 32'd0);
    tick(); expect_st("to.drop", DROP);
    check("to.err_pulse", 32'(timeout_err), 32'd1);
    tick(); expect_st("to.drop2", DROP);
    check("to.err_clear", 32'(timeout_err), 32'd0);
    packet_valid = 1'b0;
    tick(); expect_st("to.da", DA);
    packet_valid = 1'b1; fifo_empty = 3'b111;
    tick(); expect_st("to.lfd", LFD);
`else
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (state_o !== WTE || timeout_err !== 1'b0) bad++;
    end
    check("to.wte100", 32'(bad), 32'd0);
    fifo_empty = 3'b111;
    tick(); expect_st("to.lfd", LFD);
`endif
    tick(); expect_st("rst.ld", LD);

    // Synchronous reset mid-packet
    resetn = 1'b0;
    tick(); expect_st("rst.da", DA);
    check("rst.port_sel", 32'(port_sel), 32'd0);
    check("rst.timeout_err", 32'(timeout_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
